// File: rtl/pipe_pkg.sv
// pipe_pkg: widths, ALU encodings and the packed control bundle
// shared by the ID/EX stage, its hazard compare and the EX stage.
package pipe_pkg;

   localparam int DW = 32;
   localparam int RW = 5;
   localparam int AW = 4;

   localparam logic [AW-1:0] ALU_AND = 4'b0000;
   localparam logic [AW-1:0] ALU_OR  = 4'b0001;
   localparam logic [AW-1:0] ALU_ADD = 4'b0010;
   localparam logic [AW-1:0] ALU_SUB = 4'b0110;
   localparam logic [AW-1:0] ALU_SLT = 4'b0111;

   typedef struct packed {
      logic          reg_wr;
      logic          reg_dst;
      logic          alu_src;
      logic          mem_wr;
      logic          memto_reg;
      logic          branch;
      logic [AW-1:0] alu_ctr;
   } ctrl_t;

   // A bubble is the all-zero bundle: no write, no memory, ALU code 0.
   localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: combinational load-use compare between EX and ID.
// Ports: EX load flags and rt, ID rs/rt and uses_rt in; hazard out.
module load_use_detect
   import pipe_pkg::*;
(
   input  logic          ex_memto_reg,
   input  logic          ex_reg_wr,
   input  logic [RW-1:0] ex_rt,
   input  logic [RW-1:0] id_rs,
   input  logic [RW-1:0] id_rt,
   input  logic          uses_rt,
   output logic          hazard
);

   logic ex_is_load;
   logic rs_hit;
   logic rt_hit;

   always_comb begin
      ex_is_load = ex_memto_reg & ex_reg_wr & (ex_rt != '0);
      rs_hit     = (ex_rt == id_rs);
      rt_hit     = uses_rt & (ex_rt == id_rt);
      hazard     = ex_is_load & (rs_hit | rt_hit);
   end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX register with immediate extension, flush/load-use
// bubbles, PC and IF/ID freeze, and a saturating stall counter.
module id_ex_stage
   import pipe_pkg::*;
#(
   parameter int DW = pipe_pkg::DW,
   parameter int CW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic [RW-1:0] IF_ID_rs,
   input  logic [RW-1:0] IF_ID_rt,
   input  logic [RW-1:0] IF_ID_rd,
   input  logic [15:0]   IF_ID_imm,
   input  logic [DW-1:0] IF_ID_pc4,
   input  logic [DW-1:0] busA,
   input  logic [DW-1:0] busB,
   input  logic          RegWr,
   input  logic          RegDst,
   input  logic          ALUSrc,
   input  logic          MemWr,
   input  logic          MemtoReg,
   input  logic          Branch,
   input  logic          ExtOp,
   input  logic [AW-1:0] ALUctr,
   output logic [RW-1:0] ID_Ex_rs,
   output logic [RW-1:0] ID_Ex_rt,
   output logic [RW-1:0] ID_Ex_rd,
   output logic [DW-1:0] ID_Ex_busA,
   output logic [DW-1:0] ID_Ex_busB,
   output logic [DW-1:0] ID_Ex_imm32,
   output logic [DW-1:0] ID_Ex_pc4,
   output logic          ID_Ex_RegWr,
   output logic          ID_Ex_RegDst,
   output logic          ID_Ex_ALUSrc,
   output logic          ID_Ex_MemWr,
   output logic          ID_Ex_MemtoReg,
   output logic          ID_Ex_Branch,
   output logic [AW-1:0] ID_Ex_ALUctr,
   output logic          PCWr,
   output logic          IF_ID_Wr,
   output logic [CW-1:0] stall_cnt
);

   ctrl_t         ctrl_q, ctrl_d, ctrl_in;
   logic [RW-1:0] rs_q, rs_d;
   logic [RW-1:0] rt_q, rt_d;
   logic [RW-1:0] rd_q, rd_d;
   logic [DW-1:0] bus_a_q, bus_a_d;
   logic [DW-1:0] bus_b_q, bus_b_d;
   logic [DW-1:0] imm32_q, imm32_d;
   logic [DW-1:0] pc4_q, pc4_d;
   logic [CW-1:0] stall_cnt_q, stall_cnt_d;
   logic [CW-1:0] cnt_inc;
   logic [DW-1:0] imm_ext;
   logic          uses_rt;
   logic          hazard;
   logic          bubble;
   logic          freeze;

   load_use_detect u_lud (
      .ex_memto_reg (ctrl_q.memto_reg),
      .ex_reg_wr    (ctrl_q.reg_wr),
      .ex_rt        (rt_q),
      .id_rs        (IF_ID_rs),
      .id_rt        (IF_ID_rt),
      .uses_rt      (uses_rt),
      .hazard       (hazard)
   );

   always_comb begin
      uses_rt = RegDst | MemWr | Branch;

      ctrl_in.reg_wr    = RegWr;
      ctrl_in.reg_dst   = RegDst;
      ctrl_in.alu_src   = ALUSrc;
      ctrl_in.mem_wr    = MemWr;
      ctrl_in.memto_reg = MemtoReg;
      ctrl_in.branch    = Branch;
      ctrl_in.alu_ctr   = ALUctr;

      imm_ext = {{(DW-16){ExtOp & IF_ID_imm[15]}}, IF_ID_imm};

      cnt_inc = (stall_cnt_q == '1) ? stall_cnt_q
                                    : stall_cnt_q + CW'(1);

      bubble      = 1'b0;
      freeze      = 1'b0;
      stall_cnt_d = stall_cnt_q;

      // Flush outranks the hazard: the dependent instruction is being
      // killed upstream anyway, so neither freeze nor count.
      unique case (1'b1)
         flush: begin
            bubble = 1'b1;
         end
         (hazard & ~flush): begin
            bubble      = 1'b1;
            freeze      = 1'b1;
            stall_cnt_d = cnt_inc;
         end
         default: ;
      endcase

      if (bubble) begin
         ctrl_d  = CTRL_BUBBLE;
         rs_d    = '0;
         rt_d    = '0;
         rd_d    = '0;
         bus_a_d = '0;
         bus_b_d = '0;
         imm32_d = '0;
         pc4_d   = '0;
      end else begin
         ctrl_d  = ctrl_in;
         rs_d    = IF_ID_rs;
         rt_d    = IF_ID_rt;
         rd_d    = IF_ID_rd;
         bus_a_d = busA;
         bus_b_d = busB;
         imm32_d = imm_ext;
         pc4_d   = IF_ID_pc4;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ctrl_q      <= CTRL_BUBBLE;
         rs_q        <= '0;
         rt_q        <= '0;
         rd_q        <= '0;
         bus_a_q     <= '0;
         bus_b_q     <= '0;
         imm32_q     <= '0;
         pc4_q       <= '0;
         stall_cnt_q <= '0;
      end else begin
         ctrl_q      <= ctrl_d;
         rs_q        <= rs_d;
         rt_q        <= rt_d;
         rd_q        <= rd_d;
         bus_a_q     <= bus_a_d;
         bus_b_q     <= bus_b_d;
         imm32_q     <= imm32_d;
         pc4_q       <= pc4_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign ID_Ex_rs       = rs_q;
   assign ID_Ex_rt       = rt_q;
   assign ID_Ex_rd       = rd_q;
   assign ID_Ex_busA     = bus_a_q;
   assign ID_Ex_busB     = bus_b_q;
   assign ID_Ex_imm32    = imm32_q;
   assign ID_Ex_pc4      = pc4_q;
   assign ID_Ex_RegWr    = ctrl_q.reg_wr;
   assign ID_Ex_RegDst   = ctrl_q.reg_dst;
   assign ID_Ex_ALUSrc   = ctrl_q.alu_src;
   assign ID_Ex_MemWr    = ctrl_q.mem_wr;
   assign ID_Ex_MemtoReg = ctrl_q.memto_reg;
   assign ID_Ex_Branch   = ctrl_q.branch;
   assign ID_Ex_ALUctr   = ctrl_q.alu_ctr;
   assign PCWr           = ~freeze;
   assign IF_ID_Wr       = ~freeze;
   assign stall_cnt      = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: scoreboard bench for the ID/EX stage.
// Directed MIPS sequences; expected EX state queued at drive time.
module tb_id_ex_stage;
   import pipe_pkg::*;

   localparam int DW = 32;
   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          flush;
   logic [4:0]    IF_ID_rs, IF_ID_rt, IF_ID_rd;
   logic [15:0]   IF_ID_imm;
   logic [DW-1:0] IF_ID_pc4, busA, busB;
   logic          RegWr, RegDst, ALUSrc, MemWr;
   logic          MemtoReg, Branch, ExtOp;
   logic [3:0]    ALUctr;
   logic [4:0]    ID_Ex_rs, ID_Ex_rt, ID_Ex_rd;
   logic [DW-1:0] ID_Ex_busA, ID_Ex_busB;
   logic [DW-1:0] ID_Ex_imm32, ID_Ex_pc4;
   logic          ID_Ex_RegWr, ID_Ex_RegDst, ID_Ex_ALUSrc;
   logic          ID_Ex_MemWr, ID_Ex_MemtoReg, ID_Ex_Branch;
   logic [3:0]    ID_Ex_ALUctr;
   logic          PCWr, IF_ID_Wr;
   logic [CW-1:0] stall_cnt;

   id_ex_stage #(.DW(DW), .CW(CW)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .IF_ID_rs(IF_ID_rs), .IF_ID_rt(IF_ID_rt),
      .IF_ID_rd(IF_ID_rd), .IF_ID_imm(IF_ID_imm),
      .IF_ID_pc4(IF_ID_pc4), .busA(busA), .busB(busB),
      .RegWr(RegWr), .RegDst(RegDst), .ALUSrc(ALUSrc),
      .MemWr(MemWr), .MemtoReg(MemtoReg), .Branch(Branch),
      .ExtOp(ExtOp), .ALUctr(ALUctr),
      .ID_Ex_rs(ID_Ex_rs), .ID_Ex_rt(ID_Ex_rt),
      .ID_Ex_rd(ID_Ex_rd), .ID_Ex_busA(ID_Ex_busA),
      .ID_Ex_busB(ID_Ex_busB), .ID_Ex_imm32(ID_Ex_imm32),
      .ID_Ex_pc4(ID_Ex_pc4), .ID_Ex_RegWr(ID_Ex_RegWr),
      .ID_Ex_RegDst(ID_Ex_RegDst), .ID_Ex_ALUSrc(ID_Ex_ALUSrc),
      .ID_Ex_MemWr(ID_Ex_MemWr), .ID_Ex_MemtoReg(ID_Ex_MemtoReg),
      .ID_Ex_Branch(ID_Ex_Branch), .ID_Ex_ALUctr(ID_Ex_ALUctr),
      .PCWr(PCWr), .IF_ID_Wr(IF_ID_Wr), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]    rs, rt, rd;
      logic [DW-1:0] a, b, imm, pc4;
      logic [9:0]    ctrl;
      logic [CW-1:0] cnt;
   } st_t;

   st_t model;
   st_t sb_q[$];
   int  checks = 0;
   int  failures = 0;

   task automatic check(input string tag,
                        input logic [63:0] got,
                        input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [9:0] got_ctrl();
      return {ID_Ex_RegWr, ID_Ex_RegDst, ID_Ex_ALUSrc, ID_Ex_MemWr,
              ID_Ex_MemtoReg, ID_Ex_Branch, ID_Ex_ALUctr};
   endfunction

   task automatic check_zero(input string tag);
      check({tag, "_rs"},   64'(ID_Ex_rs), 64'd0);
      check({tag, "_rt"},   64'(ID_Ex_rt), 64'd0);
      check({tag, "_rd"},   64'(ID_Ex_rd), 64'd0);
      check({tag, "_a"},    64'(ID_Ex_busA), 64'd0);
      check({tag, "_b"},    64'(ID_Ex_busB), 64'd0);
      check({tag, "_imm"},  64'(ID_Ex_imm32), 64'd0);
      check({tag, "_pc4"},  64'(ID_Ex_pc4), 64'd0);
      check({tag, "_ctrl"}, 64'(got_ctrl()), 64'd0);
      check({tag, "_cnt"},  64'(stall_cnt), 64'd0);
      check({tag, "_pcwr"}, 64'(PCWr), 64'd1);
      check({tag, "_ifid"}, 64'(IF_ID_Wr), 64'd1);
   endtask

   // One ID instruction for one cycle. 'stall' is the freeze this
   // sequence is known to require; 'do_rst' pulses reset mid-cycle.
   task automatic step(input string tag,
                       input logic [4:0] rs, rt, rd,
                       input logic [15:0] imm,
                       input logic rw, rdst, asrc, mw, m2r, br, ext,
                       input logic [3:0] alu,
                       input logic fl, stall, do_rst);
      st_t e;
      @(negedge clk);
      IF_ID_rs = rs; IF_ID_rt = rt; IF_ID_rd = rd;
      IF_ID_imm = imm; IF_ID_pc4 = $urandom;
      busA = $urandom; busB = $urandom;
      RegWr = rw; RegDst = rdst; ALUSrc = asrc; MemWr = mw;
      MemtoReg = m2r; Branch = br; ExtOp = ext; ALUctr = alu;
      flush = fl;
      #1;
      if (do_rst) begin
         rst = 1'b1;
         #1;
         check_zero({tag, "_rst"});
         rst = 1'b0;
         model = '{default: '0};
         sb_q.delete();
         #1;
      end
      check({tag, "_pcwr"}, 64'(PCWr), 64'(!stall));
      check({tag, "_ifidwr"}, 64'(IF_ID_Wr), 64'(!stall));
      e = model;
      if (fl || stall) begin
         e.rs = '0; e.rt = '0; e.rd = '0;
         e.a = '0; e.b = '0; e.imm = '0; e.pc4 = '0; e.ctrl = '0;
      end else begin
         e.rs = rs; e.rt = rt; e.rd = rd;
         e.a = busA; e.b = busB; e.pc4 = IF_ID_pc4;
         e.imm = ext ? {{16{imm[15]}}, imm} : {16'h0000, imm};
         e.ctrl = {rw, rdst, asrc, mw, m2r, br, alu};
      end
      if (stall && !fl && model.cnt != {CW{1'b1}})
         e.cnt = model.cnt + 1'b1;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
         check({tag, "_sb_empty"}, 64'd1, 64'd0);
      end else begin
         e = sb_q.pop_front();
         check({tag, "_rs"},   64'(ID_Ex_rs), 64'(e.rs));
         check({tag, "_rt"},   64'(ID_Ex_rt), 64'(e.rt));
         check({tag, "_rd"},   64'(ID_Ex_rd), 64'(e.rd));
         check({tag, "_a"},    64'(ID_Ex_busA), 64'(e.a));
         check({tag, "_b"},    64'(ID_Ex_busB), 64'(e.b));
         check({tag, "_imm"},  64'(ID_Ex_imm32), 64'(e.imm));
         check({tag, "_pc4"},  64'(ID_Ex_pc4), 64'(e.pc4));
         check({tag, "_ctrl"}, 64'(got_ctrl()), 64'(e.ctrl));
         check({tag, "_cnt"},  64'(stall_cnt), 64'(e.cnt));
         model = e;
      end
   endtask

   task automatic lw(input string tag, input logic [4:0] rt, rs,
                     input logic fl, stall);
      step(tag, rs, rt, 5'd0, 16'h0004,
           1, 0, 1, 0, 1, 0, 1, ALU_ADD, fl, stall, 0);
   endtask

   task automatic add(input string tag, input logic [4:0] rd, rs, rt,
                      input logic fl, stall, do_rst);
      step(tag, rs, rt, rd, 16'h0020,
           1, 1, 0, 0, 0, 0, 0, ALU_ADD, fl, stall, do_rst);
   endtask

   task automatic addi(input string tag, input logic [4:0] rt, rs,
                       input logic [15:0] imm, input logic stall);
      step(tag, rs, rt, 5'd0, imm,
           1, 0, 1, 0, 0, 0, 1, ALU_ADD, 0, stall, 0);
   endtask

   task automatic ori(input string tag, input logic [4:0] rt, rs,
                      input logic [15:0] imm, input logic stall);
      step(tag, rs, rt, 5'd0, imm,
           1, 0, 1, 0, 0, 0, 0, ALU_OR, 0, stall, 0);
   endtask

   initial begin
      model = '{default: '0};
      rst = 1'b1; flush = 1'b0;
      IF_ID_rs = '0; IF_ID_rt = '0; IF_ID_rd = '0;
      IF_ID_imm = '0; IF_ID_pc4 = '0; busA = '0; busB = '0;
      RegWr = 0; RegDst = 0; ALUSrc = 0; MemWr = 0;
      MemtoReg = 0; Branch = 0; ExtOp = 0; ALUctr = '0;
      #2;
      check_zero("por");
      @(negedge clk);
      rst = 1'b0;

      lw  ("lu_rs_lw",   5'd2, 5'd1, 0, 0);
      add ("lu_rs_stl",  5'd3, 5'd2, 5'd4, 0, 1, 0);
      add ("lu_rs_go",   5'd3, 5'd2, 5'd4, 0, 0, 0);
      check("lu_rs_cnt", 64'(stall_cnt), 64'd1);
      check("lu_rs_rs2", 64'(ID_Ex_rs), 64'd2);

      lw  ("lu_rt_lw",   5'd4, 5'd1, 0, 0);
      add ("lu_rt_stl",  5'd3, 5'd1, 5'd4, 0, 1, 0);
      add ("lu_rt_go",   5'd3, 5'd1, 5'd4, 0, 0, 0);

      lw  ("addi_lw",    5'd5, 5'd1, 0, 0);
      addi("addi_stl",   5'd6, 5'd5, 16'h0001, 1);
      addi("addi_go",    5'd6, 5'd5, 16'h0001, 0);
      lw  ("ori_lw",     5'd5, 5'd1, 0, 0);
      ori ("ori_nostl",  5'd5, 5'd7, 16'h0001, 0);

      lw  ("r0_lw",      5'd0, 5'd1, 0, 0);
      add ("r0_nostl",   5'd3, 5'd0, 5'd0, 0, 0, 0);

      lw  ("fl_lw",      5'd2, 5'd1, 0, 0);
      add ("fl_kill",    5'd3, 5'd2, 5'd4, 1, 0, 0);
      check("fl_cnt",    64'(stall_cnt), 64'd3);

      addi("ext_sign",   5'd8, 5'd9, 16'h8000, 0);
      check("ext_s32",   64'(ID_Ex_imm32), 64'hFFFF8000);
      ori ("ext_zero",   5'd8, 5'd9, 16'h8000, 0);
      check("ext_z32",   64'(ID_Ex_imm32), 64'h00008000);

      lw  ("mid_lw",     5'd2, 5'd1, 0, 0);
      add ("mid_rst",    5'd3, 5'd2, 5'd4, 0, 0, 1);

      lw("sat_lw0", 5'd2, 5'd2, 0, 0);
      for (int i = 0; i < 260; i++) begin
         lw("sat_stl", 5'd2, 5'd2, 0, 1);
         lw("sat_go",  5'd2, 5'd2, 0, 0);
      end
      check("sat_cnt", 64'(stall_cnt), 64'(8'hFF));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout t=%0t", $time);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register with integrated load-use hazard detection for the five-stage MIPS pipeline. It captures decoded control and operands from the ID stage every cycle. It inserts a bubble and freezes PC and IF/ID on a load-use dependency, and inserts a bubble on a branch flush. Its registered rs/rt and control outputs feed the EX-stage forwarding unit and ALU muxes directly.

## Interface
Parameters:
- DW, 32, datapath width (PC+4, bus, immediate-extended width)
- CW, 16, stall-counter width

Ports:
- clk  in  1  pipeline clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  branch taken in EX/MEM; kill the instruction entering EX
- IF_ID_rs, IF_ID_rt, IF_ID_rd  in  5 each  register specifiers of the instruction in ID
- IF_ID_imm  in  16  raw immediate
- IF_ID_pc4  in  DW  PC+4 of the ID instruction
- busA, busB  in  DW  register-file read data
- RegWr, RegDst, ALUSrc, MemWr, MemtoReg, Branch, ExtOp  in  1 each  decoder control
- ALUctr  in  4  decoder ALU operation
- ID_Ex_rs, ID_Ex_rt, ID_Ex_rd  out  5 each  registered specifiers; rs and rt go to forwarding
- ID_Ex_busA, ID_Ex_busB, ID_Ex_imm32, ID_Ex_pc4  out  DW each  registered operands; imm32 is already extended
- ID_Ex_RegWr, ID_Ex_RegDst, ID_Ex_ALUSrc, ID_Ex_MemWr, ID_Ex_MemtoReg, ID_Ex_Branch  out  1 each  registered control
- ID_Ex_ALUctr  out  4  registered ALU operation
- PCWr  out  1  combinational; 0 freezes the PC
- IF_ID_Wr  out  1  combinational; 0 freezes the IF/ID register
- stall_cnt  out  CW  saturating count of load-use bubbles inserted

## Operation
- Immediate extension is done at capture: ExtOp=1 sign-extends, ExtOp=0 zero-extends, IF_ID_imm to DW bits.
- The ID instruction uses rt as a source when `uses_rt = RegDst | MemWr | Branch`. The rs field is always treated as a source.
- A load-use hazard exists when all of the following hold:
  - ID_Ex_MemtoReg = 1
  - ID_Ex_RegWr = 1
  - ID_Ex_rt != 0
  - ID_Ex_rt == IF_ID_rs, or (uses_rt and ID_Ex_rt == IF_ID_rt)
- Per-cycle action, in priority order:
  - flush = 1: load a bubble. PCWr = 1, IF_ID_Wr = 1. stall_cnt is unchanged.
  - hazard = 1, no flush: load a bubble. PCWr = 0, IF_ID_Wr = 0. stall_cnt increments.
  - otherwise: capture all inputs. PCWr = 1, IF_ID_Wr = 1.
- A bubble means all ID_Ex control outputs are 0 and ID_Ex_ALUctr = 0. Specifiers, buses, imm32 and pc4 are also cleared to 0, so a bubble can never match for forwarding.
- stall_cnt saturates at all-ones and holds there; it never wraps.
- Consecutive loads: a frozen instruction is re-evaluated the next cycle against the bubble. The bubble has MemtoReg = 0, so at most one bubble is inserted per load-use pair.

## Timing
- Register latency: inputs sampled at edge N appear on ID_Ex_* after edge N.
- PCWr and IF_ID_Wr are purely combinational from the current ID_Ex_* state and the IF_ID_* inputs and flush, within the same cycle. There is no registered stall state.
- Reset (asynchronous, immediate, independent of clk):
  - every ID_Ex_* output = 0
  - stall_cnt = 0
  - consequently PCWr = 1 and IF_ID_Wr = 1
- Reset released mid-stall: the pipeline resumes with a bubble in EX and no pending stall.
- flush coincident with a hazard: flush wins. No freeze and no count; the load-dependent instruction is discarded by the upstream IF/ID flush.

## Structure
- Shared package pipe_pkg holds:
  - DW, the 5-bit register-index width, the ALUctr width and encodings
  - a packed control-bundle type, so that a bubble is a single zero constant CTRL_BUBBLE
- Sub-module load_use_detect: a combinational hazard compare taking ID_Ex_MemtoReg, ID_Ex_RegWr, ID_Ex_rt, IF_ID_rs, IF_ID_rt and uses_rt, and producing hazard. It is reused by any future early-branch stall logic.
- The top level holds the register bank, the extender, the priority mux and the counter.

## Test plan
- Reset mid-operation: load registers with non-zero values, pulse rst between clock edges. All ID_Ex_* = 0 and stall_cnt = 0 immediately, PCWr = 1.
- Load-use on rs: `lw $2,0($1)` captured, then ID holds `add $3,$2,$4`. In that cycle PCWr = 0 and IF_ID_Wr = 0. The next ID_Ex is a bubble with RegWr = 0. The cycle after, add is captured with ID_Ex_rs = 2. stall_cnt = 1.
- rt use gating: `lw $5`, then `addi $6,$5,1`, which is rs-only (hazard, stall), versus `ori $5,$7,1` with RegDst = 0, MemWr = 0, Branch = 0 and IF_ID_rt = 5 (no stall, PCWr = 1).
- Register-0 exclusion: `lw $0` followed by `add $3,$0,$0` gives no stall and stall_cnt unchanged.
- Flush priority: load-use condition and flush = 1 in the same cycle give PCWr = 1, a bubble, and stall_cnt unchanged.
- Saturation and extension: preload stall_cnt to 16'hFFFF via repeated stalls; one more stall keeps it at 16'hFFFF. With imm = 16'h8000: ExtOp = 1 gives imm32 = 32'hFFFF8000, ExtOp = 0 gives 32'h00008000.
